// File: rtl/pcie_crdt_tracker.sv
// pcie_crdt_tracker: PCIe TX credit init handshake, per-type pool accumulation and request grant/debit.
// Define PCIE_CRDT_INFINITE_EN to treat pools still empty at the end of COLLECT as infinite.
module pcie_crdt_tracker #(
  parameter int HDR_CNT_W   = 8,
  parameter int DATA_CNT_W  = 12,
  parameter int REQ_DATA_W  = 8,
  parameter int INIT_WAIT   = 16,
  parameter int INIT_WINDOW = 64
) (
  input  logic                  CLK,
  input  logic                  RESET,
  output logic                  CRDT_INIT_DONE,
  input  logic [5:0]            CRDT_UPDATE,
  input  logic [1:0]            CRDT_CNT_PH,
  input  logic [1:0]            CRDT_CNT_NPH,
  input  logic [1:0]            CRDT_CNT_CPLH,
  input  logic [3:0]            CRDT_CNT_PD,
  input  logic [3:0]            CRDT_CNT_NPD,
  input  logic [3:0]            CRDT_CNT_CPLD,
  input  logic                  REQ_VLD,
  input  logic [1:0]            REQ_TYPE,
  input  logic [REQ_DATA_W-1:0] REQ_DATA_CRDT,
  output logic                  REQ_ACK,
  output logic [HDR_CNT_W-1:0]  AVAIL_PH,
  output logic [HDR_CNT_W-1:0]  AVAIL_NPH,
  output logic [HDR_CNT_W-1:0]  AVAIL_CPLH,
  output logic [DATA_CNT_W-1:0] AVAIL_PD,
  output logic [DATA_CNT_W-1:0] AVAIL_NPD,
  output logic [DATA_CNT_W-1:0] AVAIL_CPLD,
  output logic                  READY,
  output logic                  CRDT_ERR
);
  localparam int MX = INIT_WAIT > INIT_WINDOW ? INIT_WAIT : INIT_WINDOW;
  localparam int CW = $clog2(MX + 1);
  typedef enum logic [1:0] {S_WAIT, S_COLLECT, S_RUN} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic init_q, err_q, err_d, hdr_ok, dat_ok;
  logic [2:0][HDR_CNT_W-1:0] hp_q, hp_d;
  logic [2:0][DATA_CNT_W-1:0] dp_q, dp_d;
  logic [2:0][1:0] hinc;
  logic [2:0][3:0] dinc;
  logic [HDR_CNT_W:0] hs;
  logic [DATA_CNT_W:0] ds;
  logic [5:0] inf, upd_en;
  assign hinc = {CRDT_CNT_CPLH, CRDT_CNT_NPH, CRDT_CNT_PH};
  assign dinc = {CRDT_CNT_CPLD, CRDT_CNT_NPD, CRDT_CNT_PD};
  assign upd_en = CRDT_UPDATE & ~inf & {6{state_q != S_WAIT}};
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_WAIT;
      cnt_q   <= '0;
      init_q  <= 1'b0;
      err_q   <= 1'b0;
      hp_q    <= '0;
      dp_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      init_q  <= init_q | (state_d == S_COLLECT);
      err_q   <= err_d;
      hp_q    <= hp_d;
      dp_q    <= dp_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    if (state_q == S_WAIT && cnt_q == CW'(INIT_WAIT - 1)) begin
      state_d = S_COLLECT;
      cnt_d   = '0;
    end else if (state_q == S_COLLECT && cnt_q == CW'(INIT_WINDOW - 1)) begin
      state_d = S_RUN;
      cnt_d   = '0;
    end else if (state_q == S_RUN) begin
      cnt_d = '0;
    end
  end
  // Grant looks only at registered pools; same-cycle updates never bypass into it.
  always_comb begin
    READY  = state_q == S_RUN;
    hdr_ok = 1'b0;
    dat_ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (REQ_TYPE == 2'(i)) begin
        hdr_ok = inf[i] | (hp_q[i] != '0);
        dat_ok = inf[i+3] | (dp_q[i] >= DATA_CNT_W'(REQ_DATA_CRDT));
      end
    end
    REQ_ACK = REQ_VLD & READY & hdr_ok & dat_ok;
  end
  always_comb begin
    err_d = err_q | (state_q == S_WAIT && CRDT_UPDATE != '0) | (READY && REQ_VLD && REQ_TYPE == 2'd3);
    hp_d  = hp_q;
    dp_d  = dp_q;
    hs    = '0;
    ds    = '0;
    for (int i = 0; i < 3; i++) begin
      hs = {1'b0, hp_q[i]} + (HDR_CNT_W+1)'(upd_en[i] ? hinc[i] : 2'd0)
         - (HDR_CNT_W+1)'(REQ_ACK && REQ_TYPE == 2'(i) && !inf[i]);
      hp_d[i] = hs[HDR_CNT_W] ? '1 : hs[HDR_CNT_W-1:0];
      ds = {1'b0, dp_q[i]} + (DATA_CNT_W+1)'(upd_en[i+3] ? dinc[i] : 4'd0)
         - (DATA_CNT_W+1)'((REQ_ACK && REQ_TYPE == 2'(i) && !inf[i+3]) ? REQ_DATA_CRDT : '0);
      dp_d[i] = ds[DATA_CNT_W] ? '1 : ds[DATA_CNT_W-1:0];
      err_d = err_d | hs[HDR_CNT_W] | ds[DATA_CNT_W];
    end
  end
`ifdef PCIE_CRDT_INFINITE_EN
  logic [5:0] inf_q;
  always_ff @(posedge CLK) begin
    if (RESET) inf_q <= '0;
    else if (state_q == S_COLLECT && state_d == S_RUN)
      inf_q <= {dp_d[2] == '0, dp_d[1] == '0, dp_d[0] == '0, hp_d[2] == '0, hp_d[1] == '0, hp_d[0] == '0};
  end
  assign inf = inf_q;
`else
  assign inf = '0;
`endif
  assign CRDT_INIT_DONE = init_q;
  assign CRDT_ERR       = err_q;
  assign AVAIL_PH   = inf[0] ? '1 : hp_q[0];
  assign AVAIL_NPH  = inf[1] ? '1 : hp_q[1];
  assign AVAIL_CPLH = inf[2] ? '1 : hp_q[2];
  assign AVAIL_PD   = inf[3] ? '1 : dp_q[0];
  assign AVAIL_NPD  = inf[4] ? '1 : dp_q[1];
  assign AVAIL_CPLD = inf[5] ? '1 : dp_q[2];
endmodule

// File: tb/tb_pcie_crdt_tracker.sv
// tb_pcie_crdt_tracker: directed vector table plus hand-written init, infinite-pool and saturation sequences.
module tb_pcie_crdt_tracker;
`ifdef PCIE_CRDT_INFINITE_EN
  localparam bit INF = 1'b1;
`else
  localparam bit INF = 1'b0;
`endif
  logic clk = 1'b0, rst, init_done, vld, ack, ready, err;
  logic [5:0] upd;
  logic [1:0] cph, cnph, ccplh, typ;
  logic [3:0] cpd, cnpd, ccpld;
  logic [7:0] dcr, aph, anph, acplh;
  logic [11:0] apd, anpd, acpld;
  int checks = 0, fails = 0;
  typedef struct {
    logic [5:0] upd; logic [1:0] hc; logic [3:0] dc;
    logic vld; logic [1:0] typ; logic [7:0] dcr; logic ack;
    logic [7:0] ph, nph, cplh; logic [11:0] pd, npd;
  } vec_t;
  vec_t v[8];
  always #5 clk = ~clk;
  pcie_crdt_tracker dut (
    .CLK(clk), .RESET(rst), .CRDT_INIT_DONE(init_done), .CRDT_UPDATE(upd),
    .CRDT_CNT_PH(cph), .CRDT_CNT_NPH(cnph), .CRDT_CNT_CPLH(ccplh),
    .CRDT_CNT_PD(cpd), .CRDT_CNT_NPD(cnpd), .CRDT_CNT_CPLD(ccpld),
    .REQ_VLD(vld), .REQ_TYPE(typ), .REQ_DATA_CRDT(dcr), .REQ_ACK(ack),
    .AVAIL_PH(aph), .AVAIL_NPH(anph), .AVAIL_CPLH(acplh),
    .AVAIL_PD(apd), .AVAIL_NPD(anpd), .AVAIL_CPLD(acpld),
    .READY(ready), .CRDT_ERR(err)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic idle_in;
    upd = '0; cph = '0; cnph = '0; ccplh = '0; cpd = '0; cnpd = '0; ccpld = '0;
    vld = 1'b0; typ = '0; dcr = '0;
  endtask
  task automatic do_reset;
    rst = 1'b1;
    idle_in;
    step;
    step;
    rst = 1'b0;
  endtask
  task automatic bring_up(input bit credits);
    int n;
    do_reset;
    n = 0;
    while (!init_done && n < 100) begin step; n++; end
    chk("init_timeout", init_done, 1);
    if (credits) begin
      for (int i = 0; i < 10; i++) begin
        upd = {1'b0, i == 0, 1'b1, i == 0, i == 0, i < 4};
        cph = 2'd3; cnph = 2'd2; ccplh = 2'd1; cpd = 4'd15; cnpd = 4'd5;
        step;
      end
      idle_in;
    end
    n = 0;
    while (!ready && n < 200) begin step; n++; end
    chk("ready_timeout", ready, 1);
  endtask
  initial begin
    int n;
    logic nz;
    v[0] = '{6'b000000, 2'd0, 4'd0, 1'b1, 2'd1, 8'd4,   1'b1, 8'd12, 8'd1, 8'd1, 12'd150, 12'd1};
    v[1] = '{6'b000000, 2'd0, 4'd0, 1'b1, 2'd1, 8'd2,   1'b0, 8'd12, 8'd1, 8'd1, 12'd150, 12'd1};
    v[2] = '{6'b010000, 2'd0, 4'd1, 1'b1, 2'd1, 8'd2,   1'b0, 8'd12, 8'd1, 8'd1, 12'd150, 12'd2};
    v[3] = '{6'b000000, 2'd0, 4'd0, 1'b1, 2'd1, 8'd2,   1'b1, 8'd12, 8'd0, 8'd1, 12'd150, 12'd0};
    v[4] = '{6'b000100, 2'd2, 4'd0, 1'b1, 2'd2, 8'd0,   1'b1, 8'd12, 8'd0, 8'd2, 12'd150, 12'd0};
    v[5] = '{6'b000001, 2'd0, 4'd0, 1'b1, 2'd0, 8'd0,   1'b1, 8'd11, 8'd0, 8'd2, 12'd150, 12'd0};
    v[6] = '{6'b000000, 2'd0, 4'd0, 1'b1, 2'd0, 8'd150, 1'b1, 8'd10, 8'd0, 8'd2, 12'd0,   12'd0};
    v[7] = '{6'b000000, 2'd0, 4'd0, 1'b1, 2'd1, 8'd0,   1'b0, 8'd10, 8'd0, 8'd2, 12'd0,   12'd0};
    do_reset;
    chk("rst_init_done", init_done, 0);
    chk("rst_ready", ready, 0);
    chk("rst_err", err, 0);
    chk("rst_ack", ack, 0);
    chk("rst_avail", {aph | anph | acplh, apd | anpd | acpld}, 0);
    nz = 1'b0;
    n = 0;
    while (!init_done && n < 100) begin step; n++; nz |= |{aph, anph, acplh, apd, anpd, acpld}; end
    chk("init_delay", n, 16);
    n = 0;
    while (!ready && n < 200) begin step; n++; nz |= |{aph, anph, acplh, apd, anpd, acpld}; end
    chk("ready_delay", n, 64);
    chk("idle_avail_zero", nz, 0);
    do_reset;
    upd = 6'b000001; cph = 2'd3;
    step;
    idle_in;
    chk("wait_upd_err", err, 1);
    chk("wait_upd_ignored", aph, 0);
    bring_up(1'b1);
    chk("err_cleared", err, 0);
    chk("init_ph", aph, 12);
    chk("init_pd", apd, 150);
    chk("init_nph", anph, 2);
    chk("init_npd", anpd, 5);
    chk("init_cplh", acplh, 1);
    chk("init_cpld", acpld, INF ? 12'hFFF : 12'd0);
    for (int i = 0; i < 8; i++) begin
      upd = v[i].upd; cph = v[i].hc; cnph = v[i].hc; ccplh = v[i].hc;
      cpd = v[i].dc; cnpd = v[i].dc; ccpld = v[i].dc;
      vld = v[i].vld; typ = v[i].typ; dcr = v[i].dcr;
      #1;
      chk($sformatf("v%0d_ack", i), ack, v[i].ack);
      step;
      chk($sformatf("v%0d_ph", i), aph, v[i].ph);
      chk($sformatf("v%0d_nph", i), anph, v[i].nph);
      chk($sformatf("v%0d_cplh", i), acplh, v[i].cplh);
      chk($sformatf("v%0d_pd", i), apd, v[i].pd);
      chk($sformatf("v%0d_npd", i), anpd, v[i].npd);
      chk($sformatf("v%0d_cpld", i), acpld, INF ? 12'hFFF : 12'd0);
      chk($sformatf("v%0d_err", i), err, 0);
    end
    idle_in;
    vld = 1'b1; typ = 2'd2; dcr = 8'd100;
    #1;
    chk("inf_ack", ack, INF);
    step;
    idle_in;
    chk("inf_cplh", acplh, INF ? 8'd1 : 8'd2);
    chk("inf_cpld", acpld, INF ? 12'hFFF : 12'd0);
    upd = 6'b100000; ccpld = 4'd5;
    step;
    idle_in;
    chk("inf_cpld_upd", acpld, INF ? 12'hFFF : 12'd5);
    chk("inf_upd_err", err, 0);
    upd = 6'b000001; cph = 2'd3;
    for (int i = 0; i < 81; i++) step;
    cph = 2'd1;
    step;
    chk("sat_pre_ph", aph, 254);
    chk("sat_pre_err", err, 0);
    cph = 2'd3;
    step;
    idle_in;
    chk("sat_ph", aph, 255);
    chk("sat_err", err, 1);
    step;
    chk("sat_ph_hold", aph, 255);
    chk("sat_err_sticky", err, 1);
    bring_up(1'b0);
    chk("t3_err_pre", err, 0);
    vld = 1'b1; typ = 2'd3; dcr = 8'd0;
    #1;
    chk("t3_ack", ack, 0);
    step;
    idle_in;
    chk("t3_err", err, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
